// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back, write-allocate data cache placed in the MEM stage
// of a simple pipeline. Each line holds valid, dirty, tag and a 256-bit block.
// Hits complete in the same cycle. A miss stalls the pipeline. If the victim
// line is dirty, its block is written back first. The missing block is then
// refilled, and the access finishes as an ordinary hit on the following cycle.
//
// Ports
//   clk_i        : single clock, rising edge
//   rst_i        : asynchronous active-low reset
//   cpu_req_i    : CPU access valid (load or store)
//   cpu_write_i  : 1 = store, 0 = load
//   cpu_addr_i   : byte address ([4:2] word, [4+INDEX_BITS:5] index, rest tag)
//   cpu_data_i   : store data
//   cpu_data_o   : load data (zero unless a read hit in IDLE)
//   cpu_stall_o  : freezes the pipeline while high
//   mem_req_o    : main-memory request
//   mem_write_o  : 1 = block writeback, 0 = block read
//   mem_addr_o   : block-aligned memory address
//   mem_data_o   : writeback block
//   mem_data_i   : refill block, word n at bits [32n+31:32n]
//   mem_ack_i    : one-cycle completion pulse from memory
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int INDEX_BITS = 4,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - 5 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;

    logic [LINES-1:0]        valid_r;
    logic [LINES-1:0]        dirty_r;
    logic [TAG_BITS-1:0]     tag_r  [LINES];
    logic [BLOCK_BITS-1:0]   data_r [LINES];

    logic [INDEX_BITS-1:0]   index_s;
    logic [2:0]              word_s;
    logic [7:0]              word_sel_s;
    logic [TAG_BITS-1:0]     tag_s;
    logic                    hit_s;
    logic                    victim_dirty_s;
    logic                    unused_addr_s;

    logic                    mem_req_r;
    logic                    mem_write_r;
    logic [31:0]             mem_addr_r;
    logic [BLOCK_BITS-1:0]   mem_data_r;

    logic                    mem_req_s;
    logic                    mem_write_s;
    logic [31:0]             mem_addr_s;
    logic [BLOCK_BITS-1:0]   mem_data_s;
    logic                    cpu_stall_s;
    logic [31:0]             cpu_data_s;

    // Address field decode and hit detection.
    assign index_s        = cpu_addr_i[4+INDEX_BITS:5];
    assign word_s         = cpu_addr_i[4:2];
    assign word_sel_s     = {word_s, 5'd0};
    assign tag_s          = cpu_addr_i[31:5+INDEX_BITS];
    assign hit_s          = cpu_req_i & valid_r[index_s] & (tag_r[index_s] == tag_s);
    assign victim_dirty_s = valid_r[index_s] & dirty_r[index_s];
    // The byte offset inside a word is not used by a word-granular cache.
    assign unused_addr_s  = ^cpu_addr_i[1:0];

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_req_i && !hit_s) begin
                    if (victim_dirty_s) begin
                        next_state_s = WRITEBACK;
                    end else begin
                        next_state_s = ALLOCATE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    next_state_s = ALLOCATE;
                end else begin
                    next_state_s = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ALLOCATE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output logic.
    // CPU-side outputs are combinational on the current state. The memory-side
    // values are computed for the next state. They are captured in registers so
    // that they are glitch-free and stay constant for the whole request. The
    // CPU holds its address stable during a stall, and the array does not
    // change outside IDLE, so these values stay constant until the ack.
    always_comb begin
        cpu_stall_s = 1'b0;
        cpu_data_s  = 32'd0;
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = 32'd0;
        mem_data_s  = {BLOCK_BITS{1'b0}};
        if (state_r == IDLE) begin
            cpu_stall_s = cpu_req_i & ~hit_s;
            if (hit_s && !cpu_write_i) begin
                cpu_data_s = data_r[index_s][word_sel_s +: 32];
            end else begin
                cpu_data_s = 32'd0;
            end
        end else begin
            cpu_stall_s = 1'b1;
            cpu_data_s  = 32'd0;
        end
        case (next_state_s)
            WRITEBACK: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                mem_addr_s  = {tag_r[index_s], index_s, 5'd0};
                mem_data_s  = data_r[index_s];
            end
            ALLOCATE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b0;
                mem_addr_s  = {tag_s, index_s, 5'd0};
                mem_data_s  = {BLOCK_BITS{1'b0}};
            end
            default: begin
                mem_req_s   = 1'b0;
                mem_write_s = 1'b0;
                mem_addr_s  = 32'd0;
                mem_data_s  = {BLOCK_BITS{1'b0}};
            end
        endcase
    end

    // Memory interface registers; reset drops an in-flight request at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_data_r  <= {BLOCK_BITS{1'b0}};
        end else begin
            mem_req_r   <= mem_req_s;
            mem_write_r <= mem_write_s;
            mem_addr_r  <= mem_addr_s;
            mem_data_r  <= mem_data_s;
        end
    end

    // Cache array updates: refill on ALLOCATE ack, merge store on IDLE write hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= {LINES{1'b0}};
            dirty_r <= {LINES{1'b0}};
            for (int i = 0; i < LINES; i++) begin
                tag_r[i]  <= {TAG_BITS{1'b0}};
                data_r[i] <= {BLOCK_BITS{1'b0}};
            end
        end else if (state_r == ALLOCATE && mem_ack_i) begin
            valid_r[index_s] <= 1'b1;
            dirty_r[index_s] <= 1'b0;
            tag_r[index_s]   <= tag_s;
            data_r[index_s]  <= mem_data_i;
        end else if (state_r == IDLE && hit_s && cpu_write_i) begin
            dirty_r[index_s]                   <= 1'b1;
            data_r[index_s][word_sel_s +: 32] <= cpu_data_i;
        end
    end

    assign cpu_stall_o = cpu_stall_s;
    assign cpu_data_o  = cpu_data_s;
    assign mem_req_o   = mem_req_r;
    assign mem_write_o = mem_write_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_data_o  = mem_data_r;

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_controller
//
// Directed bench for dcache_controller. A small main-memory model answers
// requests with a chosen delay. The expected load data for each CPU access is
// queued when the access is issued. It is popped and compared when the cache
// releases the stall.
// -----------------------------------------------------------------------------
module tb_dcache_controller;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  exp_q [$];
    logic [255:0] mem_model [logic [31:0]];

    dcache_controller #(
        .INDEX_BITS (4),
        .BLOCK_BITS (256)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a CPU access just after a clock edge and queue its expected load data.
    task automatic start(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata);
        @(posedge clk_i);
        #1;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = wdata;
        exp_q.push_back(exp_rdata);
    endtask

    // The access must complete in the current cycle: no stall, no memory request.
    task automatic finish(input string tag);
        logic [31:0] exp;
        @(negedge clk_i);
        chk({tag, "_stall"}, 256'(cpu_stall_o), 256'(1'b0));
        chk({tag, "_memreq"}, 256'(mem_req_o), 256'(1'b0));
        exp = exp_q.pop_front();
        chk({tag, "_data"}, 256'(cpu_data_o), 256'(exp));
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
    endtask

    // Wait for a memory request, check it, hold it for 'delay' cycles, then ack.
    task automatic mem_serve(input string tag, input int delay, input logic exp_write,
                             input logic [31:0] exp_addr, input logic [255:0] exp_wdata);
        logic [255:0] data0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (mem_req_o) break;
        end
        chk({tag, "_req"}, 256'(mem_req_o), 256'(1'b1));
        chk({tag, "_write"}, 256'(mem_write_o), 256'(exp_write));
        chk({tag, "_addr"}, 256'(mem_addr_o), 256'(exp_addr));
        chk({tag, "_stall"}, 256'(cpu_stall_o), 256'(1'b1));
        if (exp_write) begin
            chk({tag, "_wdata"}, mem_data_o, exp_wdata);
        end
        data0 = mem_data_o;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk_i);
            chk({tag, "_hold_req"}, 256'(mem_req_o), 256'(1'b1));
            chk({tag, "_hold_write"}, 256'(mem_write_o), 256'(exp_write));
            chk({tag, "_hold_addr"}, 256'(mem_addr_o), 256'(exp_addr));
            chk({tag, "_hold_data"}, mem_data_o, data0);
            chk({tag, "_hold_stall"}, 256'(cpu_stall_o), 256'(1'b1));
        end
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b1;
        if (exp_write) begin
            mem_model[exp_addr] = mem_data_o;
        end else if (mem_model.exists(exp_addr)) begin
            mem_data_i = mem_model[exp_addr];
        end else begin
            mem_data_i = 256'd0;
        end
        @(posedge clk_i);
        #1;
        mem_ack_i  = 1'b0;
        mem_data_i = 256'd0;
    endtask

    initial begin
        logic [255:0] blk;

        rst_i       = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'd0;
        cpu_data_i  = 32'd0;
        mem_data_i  = 256'd0;
        mem_ack_i   = 1'b0;

        blk = 256'd0;
        blk[95:64] = 32'h1234_5678;
        mem_model[32'h40] = blk;
        blk = 256'd0;
        blk[95:64] = 32'hAAAA_5555;
        mem_model[32'h240] = blk;

        // Reset state.
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_memreq", 256'(mem_req_o), 256'(1'b0));
        chk("rst_memwrite", 256'(mem_write_o), 256'(1'b0));
        chk("rst_memaddr", 256'(mem_addr_o), 256'(32'd0));
        chk("rst_memdata", mem_data_o, 256'd0);
        chk("rst_stall", 256'(cpu_stall_o), 256'(1'b0));
        chk("rst_data", 256'(cpu_data_o), 256'(32'd0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Cold read miss on 0x48.
        start(1'b0, 32'h48, 32'd0, 32'h1234_5678);
        @(negedge clk_i);
        chk("cold_miss_stall", 256'(cpu_stall_o), 256'(1'b1));
        chk("cold_miss_idle_req", 256'(mem_req_o), 256'(1'b0));
        mem_serve("cold_alloc", 5, 1'b0, 32'h40, 256'd0);
        finish("cold_done");

        // Write hit then read hit.
        start(1'b1, 32'h4C, 32'hDEAD_BEEF, 32'd0);
        finish("wr_hit");
        start(1'b0, 32'h4C, 32'd0, 32'hDEAD_BEEF);
        finish("rd_hit");

        // Dirty conflict on index 2: writeback then allocate.
        start(1'b0, 32'h248, 32'd0, 32'hAAAA_5555);
        @(negedge clk_i);
        chk("dirty_miss_stall", 256'(cpu_stall_o), 256'(1'b1));
        blk = 256'd0;
        blk[127:96] = 32'hDEAD_BEEF;
        blk[95:64]  = 32'h1234_5678;
        mem_serve("dirty_wb", 2, 1'b1, 32'h40, blk);
        mem_serve("dirty_alloc", 3, 1'b0, 32'h240, 256'd0);
        finish("dirty_done");

        // Clean conflict: allocate only, memory sees the written-back block.
        start(1'b0, 32'h48, 32'd0, 32'h1234_5678);
        mem_serve("clean_alloc", 2, 1'b0, 32'h40, 256'd0);
        finish("clean_done");

        // Dirty the line again, then a slow writeback held for 20 cycles.
        start(1'b1, 32'h44, 32'hCAFE_F00D, 32'd0);
        finish("wr_hit2");
        start(1'b0, 32'h248, 32'd0, 32'hAAAA_5555);
        blk = 256'd0;
        blk[127:96] = 32'hDEAD_BEEF;
        blk[95:64]  = 32'h1234_5678;
        blk[63:32]  = 32'hCAFE_F00D;
        mem_serve("slow_wb", 20, 1'b1, 32'h40, blk);
        mem_serve("slow_alloc", 1, 1'b0, 32'h240, 256'd0);
        finish("slow_done");

        // Reset in the middle of an ALLOCATE.
        start(1'b0, 32'h4C, 32'd0, 32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (mem_req_o) break;
        end
        chk("pre_rst_req", 256'(mem_req_o), 256'(1'b1));
        chk("pre_rst_addr", 256'(mem_addr_o), 256'(32'h40));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_req", 256'(mem_req_o), 256'(1'b0));
        chk("mid_rst_stall", 256'(cpu_stall_o), 256'(1'b1));
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        mem_serve("post_rst_alloc", 1, 1'b0, 32'h40, 256'd0);
        finish("post_rst_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL take parameter INDEX_BITS, default 4, line-index width (2^INDEX_BITS lines).
REQ-002 SHALL take parameter BLOCK_BITS, default 256, line size in bits (32 bytes, 8 words); tag width = 32-5-INDEX_BITS.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_req_i  input  1  access valid (pipeline MEM stage MemRead|MemWrite).
REQ-006 SHALL have port cpu_write_i  input  1  1=store, 0=load.
REQ-007 SHALL have port cpu_addr_i  input  32  byte address; [1:0] ignored, [4:2] word, [4+INDEX_BITS:5] index, upper bits tag.
REQ-008 SHALL have port cpu_data_i  input  32  store data.
REQ-009 SHALL have port cpu_data_o  output  32  load data.
REQ-010 SHALL have port cpu_stall_o  output  1  freezes all pipeline registers and PC while high.
REQ-011 SHALL have port mem_req_o  output  1  main-memory request.
REQ-012 SHALL have port mem_write_o  output  1  1=block writeback, 0=block read.
REQ-013 SHALL have port mem_addr_o  output  32  block-aligned address ([4:0]=0).
REQ-014 SHALL have port mem_data_o  output  BLOCK_BITS  writeback block.
REQ-015 SHALL have port mem_data_i  input  BLOCK_BITS  refill block; word n at bits [32n+31:32n].
REQ-016 SHALL have port mem_ack_i  input  1  one-cycle completion pulse from memory.

Function
REQ-017 SHALL be direct-mapped write-back write-allocate; per line: valid, dirty, tag, BLOCK_BITS data, all internal registers.
REQ-018 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-019 SHALL, in IDLE, compute hit = cpu_req_i & valid[index] & (tag[index]==addr tag) combinationally.
REQ-020 SHALL, on a read hit in IDLE, drive cpu_data_o with the addressed word in the same cycle, cpu_stall_o=0; otherwise cpu_data_o=0.
REQ-021 SHALL, on a write hit in IDLE, write cpu_data_i into the addressed word and set dirty at the clock edge, cpu_stall_o=0.
REQ-022 SHALL assert cpu_stall_o combinationally when (IDLE & cpu_req_i & ~hit) or state!=IDLE.
REQ-023 SHALL, on IDLE miss, go to WRITEBACK if victim valid&dirty, else to ALLOCATE.
REQ-024 SHALL, in WRITEBACK, drive mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag,index,5'b0}, mem_data_o=victim block; on mem_ack_i go to ALLOCATE.
REQ-025 SHALL, in ALLOCATE, drive mem_req_o=1, mem_write_o=0, mem_addr_o={addr tag,index,5'b0}; on mem_ack_i load mem_data_i into the line, set valid=1, dirty=0, tag=addr tag, go to IDLE.
REQ-026 SHALL complete the access after refill as an ordinary hit in IDLE the next cycle (miss penalty = memory cycles + 1); a store merges there and sets dirty.
REQ-027 SHALL hold mem_req_o, mem_write_o, mem_addr_o, mem_data_o stable until mem_ack_i; ack arriving in the first request cycle is legal.
REQ-028 SHALL ignore mem_ack_i in IDLE; mem_req_o=0 and mem_write_o=0 in IDLE.
REQ-029 SHALL rely on the CPU holding cpu_req_i/addr/data stable while cpu_stall_o=1; an in-flight WRITEBACK/ALLOCATE always runs to completion even if cpu_req_i drops.
REQ-030 SHALL treat a miss whose victim is invalid or clean as ALLOCATE-only (no writeback).

Reset
REQ-031 SHALL, while rst_i=0, asynchronously force state=IDLE, all valid and dirty bits to 0, mem_req_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; cpu_stall_o and cpu_data_o follow REQ-020/022 from IDLE.
REQ-032 SHALL abandon any transaction on reset mid-WRITEBACK/ALLOCATE with no array update; tag/data arrays need not be cleared.

Verification
REQ-033 Cold read: after reset, read 0x48 -> stall=1, mem_req_o=1, mem_write_o=0, mem_addr_o=0x40; ack with bits[95:64]=0x12345678 after 5 cycles -> next cycle stall=0, cpu_data_o=0x12345678.
REQ-034 Write hit: store 0xDEADBEEF to 0x4C after REQ-033 -> stall=0, no mem_req_o; then load 0x4C -> cpu_data_o=0xDEADBEEF, stall=0.
REQ-035 Dirty conflict: then load 0x248 (index 2, tag 1) -> WRITEBACK to 0x40 with mem_data_o[127:96]=0xDEADBEEF, [95:64]=0x12345678; after ack, ALLOCATE at 0x240; after ack load hits.
REQ-036 Clean conflict: load 0x48 again (line 2 now clean, tag 1) -> goes directly to ALLOCATE at 0x40, mem_write_o never asserted.
REQ-037 Slow memory: withhold mem_ack_i 20 cycles in WRITEBACK -> mem_req_o, mem_addr_o, mem_data_o, cpu_stall_o constant all 20 cycles.
REQ-038 Reset mid-ALLOCATE: pull rst_i low -> mem_req_o=0 immediately; after release, load 0x4C misses (mem_req_o=1, addr 0x40).
